// File: rtl/vita49_unpack32.sv
// VITA-49 packet unpacker: strips header, optional fields and trailer,
// forwarding payload words only, with capture of metadata and error pulses.
module vita49_unpack32 #(
    parameter bit CHECK_SEQ = 1'b1,
    parameter int TUSER_W   = 32
) (
    input  logic               AXIS_ACLK,
    input  logic               AXIS_ARESET,
    input  logic [31:0]        S_AXIS_TDATA,
    input  logic               S_AXIS_TVALID,
    input  logic               S_AXIS_TLAST,
    input  logic [TUSER_W-1:0] S_AXIS_TUSER,
    output logic               S_AXIS_TREADY,
    output logic [31:0]        M_AXIS_TDATA,
    output logic               M_AXIS_TVALID,
    output logic               M_AXIS_TLAST,
    input  logic               M_AXIS_TREADY,
    output logic [TUSER_W-1:0] M_AXIS_TUSER,
    output logic [31:0]        STREAM_ID,
    output logic [31:0]        TSI,
    output logic [31:0]        TRAILER,
    output logic [63:0]        TSF,
    output logic               HDR_STB,
    output logic               ERR_SHORT,
    output logic               ERR_LONG,
    output logic               ERR_SEQ
);

    typedef enum logic [2:0] {S_HDR, S_OPT, S_PAY, S_TRL, S_DROP} state_e;

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               t_q, t_d;
    logic               sid_q, sid_d;
    logic [1:0]         cid_q, cid_d;
    logic               tsi_q, tsi_d;
    logic [1:0]         tsf_q, tsf_d;
    logic [3:0]         seq_q, seq_d;
    logic               seqv_q, seqv_d;
    logic [31:0]        sidr_q, sidr_d;
    logic [31:0]        tsir_q, tsir_d;
    logic [63:0]        tsfr_q, tsfr_d;
    logic [31:0]        trl_q, trl_d;
    logic [TUSER_W-1:0] tuser_q, tuser_d;
    logic               hdr_q, hdr_d;
    logic               esh_q, esh_d;
    logic               elg_q, elg_d;
    logic               esq_q, esq_d;

    logic               s_rdy, m_vld, m_last, s_xfr, opt_done;

    // Header field decode, valid whenever a header word is presented
    logic [3:0]  h_type;
    logic        h_c, h_t, h_tsi, h_tsf, h_sid;
    logic [3:0]  h_cnt;
    logic [15:0] h_size;
    logic [2:0]  h_opt;
    logic [16:0] h_plen;
    logic        h_neg;

    assign h_type = S_AXIS_TDATA[31:28];
    assign h_c    = S_AXIS_TDATA[27];
    assign h_t    = S_AXIS_TDATA[26];
    assign h_tsi  = S_AXIS_TDATA[23:22] != 2'd0;
    assign h_tsf  = S_AXIS_TDATA[21:20] != 2'd0;
    assign h_cnt  = S_AXIS_TDATA[19:16];
    assign h_size = S_AXIS_TDATA[15:0];
    assign h_sid  = (h_type == 4'd1) || (h_type == 4'd3) ||
                    (h_type == 4'd4) || (h_type == 4'd5);
    assign h_opt  = {2'b0, h_sid} + {1'b0, h_c, 1'b0} +
                    {2'b0, h_tsi} + {1'b0, h_tsf, 1'b0};
    // Bit 16 set means the header claims fewer words than it needs
    assign h_plen = {1'b0, h_size} - 17'd1 - {14'd0, h_opt} - {16'd0, h_t};
    assign h_neg  = h_plen[16];

    assign S_AXIS_TREADY = s_rdy;
    assign M_AXIS_TVALID = m_vld;
    assign M_AXIS_TLAST  = m_last;
    assign M_AXIS_TDATA  = S_AXIS_TDATA;
    assign M_AXIS_TUSER  = tuser_q;
    assign STREAM_ID     = sidr_q;
    assign TSI           = tsir_q;
    assign TSF           = tsfr_q;
    assign TRAILER       = trl_q;
    assign HDR_STB       = hdr_q;
    assign ERR_SHORT     = esh_q;
    assign ERR_LONG      = elg_q;
    assign ERR_SEQ       = esq_q;

    // Next-state, handshake steering and status pulse generation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        t_d      = t_q;
        sid_d    = sid_q;
        cid_d    = cid_q;
        tsi_d    = tsi_q;
        tsf_d    = tsf_q;
        seq_d    = seq_q;
        seqv_d   = seqv_q;
        sidr_d   = sidr_q;
        tsir_d   = tsir_q;
        tsfr_d   = tsfr_q;
        trl_d    = trl_q;
        tuser_d  = tuser_q;
        hdr_d    = 1'b0;
        esh_d    = 1'b0;
        elg_d    = 1'b0;
        esq_d    = 1'b0;
        opt_done = 1'b0;
        s_rdy    = 1'b1;
        m_vld    = 1'b0;
        m_last   = 1'b0;
        if (state_q == S_PAY) begin
            s_rdy  = M_AXIS_TREADY;
            m_vld  = S_AXIS_TVALID;
            m_last = (cnt_q == 16'd1) || S_AXIS_TLAST;
        end
        s_xfr = S_AXIS_TVALID && s_rdy;
        if (s_xfr) begin
            unique case (state_q)
                S_HDR: begin
                    hdr_d   = 1'b1;
                    tuser_d = S_AXIS_TUSER;
                    cnt_d   = h_neg ? 16'd0 : h_plen[15:0];
                    t_d     = h_t;
                    sid_d   = h_sid;
                    cid_d   = {h_c, 1'b0};
                    tsi_d   = h_tsi;
                    tsf_d   = {h_tsf, 1'b0};
                    seq_d   = h_cnt;
                    seqv_d  = 1'b1;
                    if (CHECK_SEQ && seqv_q && (h_cnt != seq_q + 4'd1))
                        esq_d = 1'b1;
                    if (S_AXIS_TLAST || h_neg) begin
                        esh_d   = 1'b1;
                        state_d = S_AXIS_TLAST ? S_HDR : S_DROP;
                    end else if (h_opt != 3'd0) begin
                        state_d = S_OPT;
                    end else if (h_plen != 17'd0) begin
                        state_d = S_PAY;
                    end else if (h_t) begin
                        state_d = S_TRL;
                    end else begin
                        elg_d   = 1'b1;
                        state_d = S_DROP;
                    end
                end
                S_OPT: begin
                    if (sid_q) begin
                        sid_d  = 1'b0;
                        sidr_d = S_AXIS_TDATA;
                    end else if (cid_q != 2'd0) begin
                        cid_d = cid_q - 2'd1;
                    end else if (tsi_q) begin
                        tsi_d  = 1'b0;
                        tsir_d = S_AXIS_TDATA;
                    end else if (tsf_q == 2'd2) begin
                        tsf_d         = 2'd1;
                        tsfr_d[63:32] = S_AXIS_TDATA;
                    end else begin
                        tsf_d        = 2'd0;
                        tsfr_d[31:0] = S_AXIS_TDATA;
                    end
                    opt_done = !sid_d && (cid_d == 2'd0) &&
                               !tsi_d && (tsf_d == 2'd0);
                    if (!opt_done || cnt_q != 16'd0 || t_q) begin
                        if (S_AXIS_TLAST) begin
                            esh_d   = 1'b1;
                            state_d = S_HDR;
                        end else if (opt_done) begin
                            state_d = (cnt_q != 16'd0) ? S_PAY : S_TRL;
                        end
                    end else if (S_AXIS_TLAST) begin
                        state_d = S_HDR;
                    end else begin
                        elg_d   = 1'b1;
                        state_d = S_DROP;
                    end
                end
                S_PAY: begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        if (t_q) begin
                            if (S_AXIS_TLAST) begin
                                esh_d   = 1'b1;
                                state_d = S_HDR;
                            end else begin
                                state_d = S_TRL;
                            end
                        end else if (S_AXIS_TLAST) begin
                            state_d = S_HDR;
                        end else begin
                            elg_d   = 1'b1;
                            state_d = S_DROP;
                        end
                    end else if (S_AXIS_TLAST) begin
                        esh_d   = 1'b1;
                        state_d = S_HDR;
                    end
                end
                S_TRL: begin
                    trl_d = S_AXIS_TDATA;
                    if (S_AXIS_TLAST) begin
                        state_d = S_HDR;
                    end else begin
                        elg_d   = 1'b1;
                        state_d = S_DROP;
                    end
                end
                S_DROP: begin
                    if (S_AXIS_TLAST)
                        state_d = S_HDR;
                end
                default: state_d = S_HDR;
            endcase
        end
    end

    // State, counters, captured fields and registered pulses
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state_q <= S_HDR;
            cnt_q   <= '0;
            t_q     <= 1'b0;
            sid_q   <= 1'b0;
            cid_q   <= '0;
            tsi_q   <= 1'b0;
            tsf_q   <= '0;
            seq_q   <= '0;
            seqv_q  <= 1'b0;
            sidr_q  <= '0;
            tsir_q  <= '0;
            tsfr_q  <= '0;
            trl_q   <= '0;
            tuser_q <= '0;
            hdr_q   <= 1'b0;
            esh_q   <= 1'b0;
            elg_q   <= 1'b0;
            esq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            sid_q   <= sid_d;
            cid_q   <= cid_d;
            tsi_q   <= tsi_d;
            tsf_q   <= tsf_d;
            seq_q   <= seq_d;
            seqv_q  <= seqv_d;
            sidr_q  <= sidr_d;
            tsir_q  <= tsir_d;
            tsfr_q  <= tsfr_d;
            trl_q   <= trl_d;
            tuser_q <= tuser_d;
            hdr_q   <= hdr_d;
            esh_q   <= esh_d;
            elg_q   <= elg_d;
            esq_q   <= esq_d;
        end
    end

endmodule

// File: tb/tb_vita49_unpack32.sv
// Directed bench for vita49_unpack32: payload extraction, metadata capture,
// short/long/sequence errors, backpressure and mid-packet reset.
module tb_vita49_unpack32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic [31:0] s_tuser = '0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [31:0] m_tuser;
    logic [31:0] stream_id, tsi, trailer;
    logic [63:0] tsf;
    logic        hdr_stb, err_short, err_long, err_seq;

    int checks = 0;
    int failures = 0;
    bit rnd_en = 1'b0;

    logic [32:0] outq[$];
    int n_hdr = 0, n_sh = 0, n_lg = 0, n_sq = 0;
    int rd_idx = 0;
    int b_hdr, b_sh, b_lg, b_sq;

    vita49_unpack32 #(.CHECK_SEQ(1'b1), .TUSER_W(32)) dut (
        .AXIS_ACLK    (clk),
        .AXIS_ARESET  (rst),
        .S_AXIS_TDATA (s_tdata),
        .S_AXIS_TVALID(s_tvalid),
        .S_AXIS_TLAST (s_tlast),
        .S_AXIS_TUSER (s_tuser),
        .S_AXIS_TREADY(s_tready),
        .M_AXIS_TDATA (m_tdata),
        .M_AXIS_TVALID(m_tvalid),
        .M_AXIS_TLAST (m_tlast),
        .M_AXIS_TREADY(m_tready),
        .M_AXIS_TUSER (m_tuser),
        .STREAM_ID    (stream_id),
        .TSI          (tsi),
        .TRAILER      (trailer),
        .TSF          (tsf),
        .HDR_STB      (hdr_stb),
        .ERR_SHORT    (err_short),
        .ERR_LONG     (err_long),
        .ERR_SEQ      (err_seq)
    );

    always #5 clk = ~clk;

    // Downstream ready: constant 1 or random per cycle
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Mid-cycle monitor: record output transfers and count pulse cycles
    always @(negedge clk) begin
        if (m_tvalid && m_tready)
            outq.push_back({m_tlast, m_tdata});
        if (hdr_stb)   n_hdr++;
        if (err_short) n_sh++;
        if (err_long)  n_lg++;
        if (err_seq)   n_sq++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input bit last,
                        input logic [31:0] u);
        int n;
        n = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = u;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $error("FAIL send_timeout observed=stalled expected=ready");
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input bit last,
                              input logic [31:0] d);
        logic [63:0] obs;
        obs = (rd_idx < outq.size()) ? {31'd0, outq[rd_idx]}
                                     : 64'hBAD0_0000_0000_0000;
        chk(tag, obs, {31'd0, last, d});
        rd_idx++;
    endtask

    task automatic snap();
        b_hdr = n_hdr;
        b_sh  = n_sh;
        b_lg  = n_lg;
        b_sq  = n_sq;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_tready", {63'd0, s_tready}, 64'd1);
        chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_sid", {32'd0, stream_id}, 64'd0);
        chk("rst_tsf", tsf, 64'd0);
        chk("rst_pulses", {60'd0, hdr_stb, err_short, err_long, err_seq},
            64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Type-1 packet with stream ID and four payload words
        snap();
        send(32'h1000_0006, 1'b0, 32'h55);
        send(32'hCAFE_0001, 1'b0, 32'h0);
        send(32'hA, 1'b0, 32'h0);
        send(32'hB, 1'b0, 32'h0);
        send(32'hC, 1'b0, 32'h0);
        send(32'hD, 1'b1, 32'h0);
        settle();
        expect_out("p1_w0", 1'b0, 32'hA);
        expect_out("p1_w1", 1'b0, 32'hB);
        expect_out("p1_w2", 1'b0, 32'hC);
        expect_out("p1_w3", 1'b1, 32'hD);
        chk("p1_sid", {32'd0, stream_id}, 64'hCAFE_0001);
        chk("p1_tuser", {32'd0, m_tuser}, 64'h55);
        chk("p1_hdr", 64'(n_hdr - b_hdr), 64'd1);
        chk("p1_err", 64'((n_sh - b_sh) + (n_lg - b_lg) + (n_sq - b_sq)),
            64'd0);

        // SID, TSI, two TSF words, one payload word, trailer; backpressure
        rnd_en = 1'b1;
        snap();
        send(32'h1471_0007, 1'b0, 32'h0);
        send(32'h1111_2222, 1'b0, 32'h0);
        send(32'h6000_0001, 1'b0, 32'h0);
        send(32'h0000_0ABC, 1'b0, 32'h0);
        send(32'hDEF0_1234, 1'b0, 32'h0);
        send(32'hBEEF_0000, 1'b0, 32'h0);
        send(32'h0000_0005, 1'b1, 32'h0);
        settle();
        rnd_en = 1'b0;
        expect_out("p2_w0", 1'b1, 32'hBEEF_0000);
        chk("p2_trl", {32'd0, trailer}, 64'h5);
        chk("p2_tsf", tsf, 64'h0000_0ABC_DEF0_1234);
        chk("p2_tsi", {32'd0, tsi}, 64'h6000_0001);
        chk("p2_sid", {32'd0, stream_id}, 64'h1111_2222);
        chk("p2_err", 64'((n_sh - b_sh) + (n_lg - b_lg) + (n_sq - b_sq)),
            64'd0);

        // Size 8 truncated by TLAST on word 5
        snap();
        send(32'h1002_0008, 1'b0, 32'h0);
        send(32'h2222_0000, 1'b0, 32'h0);
        send(32'h31, 1'b0, 32'h0);
        send(32'h32, 1'b0, 32'h0);
        send(32'h33, 1'b1, 32'h0);
        settle();
        expect_out("p3_w0", 1'b0, 32'h31);
        expect_out("p3_w1", 1'b0, 32'h32);
        expect_out("p3_w2", 1'b1, 32'h33);
        chk("p3_short", 64'(n_sh - b_sh), 64'd1);
        chk("p3_long", 64'(n_lg - b_lg), 64'd0);

        // Size 4 with seven words: extra words dropped
        snap();
        send(32'h1003_0004, 1'b0, 32'h0);
        send(32'h3333_0000, 1'b0, 32'h0);
        send(32'h41, 1'b0, 32'h0);
        send(32'h42, 1'b0, 32'h0);
        send(32'h43, 1'b0, 32'h0);
        send(32'h44, 1'b0, 32'h0);
        send(32'h45, 1'b1, 32'h0);
        settle();
        expect_out("p4_w0", 1'b0, 32'h41);
        expect_out("p4_w1", 1'b1, 32'h42);
        chk("p4_long", 64'(n_lg - b_lg), 64'd1);
        chk("p4_short", 64'(n_sh - b_sh), 64'd0);
        chk("p4_nodrop_out", 64'(outq.size()), 64'(rd_idx));

        // Counts 4, 5, 7 under random backpressure
        rnd_en = 1'b1;
        snap();
        send(32'h0004_0003, 1'b0, 32'h0);
        send(32'h51, 1'b0, 32'h0);
        send(32'h52, 1'b1, 32'h0);
        send(32'h0005_0003, 1'b0, 32'h0);
        send(32'h53, 1'b0, 32'h0);
        send(32'h54, 1'b1, 32'h0);
        settle();
        chk("p5_seq_ok", 64'(n_sq - b_sq), 64'd0);
        send(32'h0007_0003, 1'b0, 32'h77);
        send(32'h55, 1'b0, 32'h0);
        send(32'h56, 1'b1, 32'h0);
        settle();
        rnd_en = 1'b0;
        chk("p5_seq_bad", 64'(n_sq - b_sq), 64'd1);
        chk("p5_hdr", 64'(n_hdr - b_hdr), 64'd3);
        expect_out("p5_w0", 1'b0, 32'h51);
        expect_out("p5_w1", 1'b1, 32'h52);
        expect_out("p5_w2", 1'b0, 32'h53);
        expect_out("p5_w3", 1'b1, 32'h54);
        expect_out("p5_w4", 1'b0, 32'h55);
        expect_out("p5_w5", 1'b1, 32'h56);
        chk("p5_tuser", {32'd0, m_tuser}, 64'h77);
        chk("p5_count", 64'(outq.size()), 64'(rd_idx));

        // Reset asserted while a payload word is on the bus
        send(32'h0008_0004, 1'b0, 32'h99);
        send(32'h61, 1'b0, 32'h0);
        s_tdata  = 32'h62;
        s_tvalid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mr_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("mr_tready", {63'd0, s_tready}, 64'd1);
        chk("mr_tuser", {32'd0, m_tuser}, 64'd0);
        chk("mr_sid", {32'd0, stream_id}, 64'd0);
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_out("mr_w0", 1'b0, 32'h61);
        chk("mr_count", 64'(outq.size()), 64'(rd_idx));
        snap();
        send(32'h0009_0003, 1'b0, 32'h0);
        send(32'h71, 1'b0, 32'h0);
        send(32'h72, 1'b1, 32'h0);
        settle();
        expect_out("ar_w0", 1'b0, 32'h71);
        expect_out("ar_w1", 1'b1, 32'h72);
        chk("ar_err", 64'((n_sh - b_sh) + (n_lg - b_lg) + (n_sq - b_sq)),
            64'd0);
        chk("ar_hdr", 64'(n_hdr - b_hdr), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
